// File: rtl/enc_pkg.sv
// Shared definitions for the 4-input sequential priority encoder:
// sizes, the presenter FSM state type and the two selection helpers.
package enc_pkg;

    localparam int N_REQ  = 4;
    localparam int CODE_W = 2;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } enc_state_e;

    // Fixed priority: bit 3 wins, bit 0 loses; empty vector yields 0.
    function automatic logic [CODE_W-1:0] fixed_pick(input logic [N_REQ-1:0] vec);
        logic [CODE_W-1:0] pick;
        casez (vec)
            4'b1???: pick = 2'd3;
            4'b01??: pick = 2'd2;
            4'b001?: pick = 2'd1;
            default: pick = 2'd0;
        endcase
        return pick;
    endfunction

    // Round-robin: search downwards starting just below the last served index,
    // wrapping modulo 4. With last = 0 the order is 3,2,1,0.
    function automatic logic [CODE_W-1:0] rr_pick(input logic [N_REQ-1:0] vec,
                                                  input logic [CODE_W-1:0] last);
        logic [CODE_W-1:0] idx;
        logic [CODE_W-1:0] pick;
        logic              found;
        pick  = 2'd0;
        found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = last - 2'd1 - k[CODE_W-1:0];
            if (!found && vec[idx]) begin
                pick  = idx;
                found = 1'b1;
            end else begin
                pick  = pick;
                found = found;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/req_edge_sync.sv
// One request line: two-flop synchronizer, a third delay flop and a rising
// edge detector. A settle counter hides the pipeline's fill after reset so a
// line that was already high while in reset does not look like a new event.
module req_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic req,
    output logic rise
);

    logic       sync1_r;
    logic       sync2_r;
    logic       sync3_r;
    logic [1:0] settle_r;

    // Synchronizer chain plus settle counter (saturates once sync3 holds a real sample).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r  <= 1'b0;
            sync2_r  <= 1'b0;
            sync3_r  <= 1'b0;
            settle_r <= 2'd0;
        end else begin
            sync1_r <= req;
            sync2_r <= sync1_r;
            sync3_r <= sync2_r;
            if (settle_r != 2'd3) begin
                settle_r <= settle_r + 2'd1;
            end else begin
                settle_r <= settle_r;
            end
        end
    end

    assign rise = sync2_r & ~sync3_r & (settle_r == 2'd3);

endmodule

// File: rtl/priority_encoder_42_seq.sv
// Sequential 4-to-2 priority encoder. Asynchronous request lines are
// synchronized and edge-detected into a pending set; an IDLE/HOLD presenter
// offers one code at a time with a valid/ready handshake.
// Optional build macro ENC_RR_EN switches selection from fixed priority
// (bit 3 highest) to round-robin with a last-served pointer.
module priority_encoder_42_seq
    import enc_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_REQ-1:0]  req,
    input  logic              ready,
    output logic [CODE_W-1:0] code,
    output logic              valid,
    output logic [N_REQ-1:0]  pending,
    output logic              overflow
);

    logic [N_REQ-1:0]  rise_s;
    logic [N_REQ-1:0]  clr_s;
    logic [N_REQ-1:0]  pending_r;
    logic [N_REQ-1:0]  pending_next_s;
    logic              overflow_r;
    logic              overflow_next_s;
    logic [CODE_W-1:0] pick_s;
    enc_state_e        state_r;
    enc_state_e        state_next_s;
    logic [CODE_W-1:0] code_r;
    logic [CODE_W-1:0] code_next_s;
    logic              valid_r;
    logic              valid_next_s;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_sync
        req_edge_sync u_sync (
            .clk   (clk),
            .rst_n (rst_n),
            .req   (req[gi]),
            .rise  (rise_s[gi])
        );
    end

`ifdef ENC_RR_EN
    logic [CODE_W-1:0] last_served_r;

    // Remember the index of the most recently accepted code.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_served_r <= 2'd0;
        end else if ((state_r == HOLD) && valid_r && ready) begin
            last_served_r <= code_r;
        end else begin
            last_served_r <= last_served_r;
        end
    end

    assign pick_s = rr_pick(pending_r, last_served_r);
`else
    assign pick_s = fixed_pick(pending_r);
`endif

    // Presenter next state: load in IDLE, hold until handshake in HOLD.
    always_comb begin
        state_next_s = state_r;
        code_next_s  = code_r;
        valid_next_s = valid_r;
        clr_s        = 4'b0000;
        case (state_r)
            IDLE: begin
                if (pending_r != 4'b0000) begin
                    code_next_s  = pick_s;
                    valid_next_s = 1'b1;
                    state_next_s = HOLD;
                end else begin
                    valid_next_s = 1'b0;
                    state_next_s = IDLE;
                end
            end
            HOLD: begin
                if (valid_r && ready) begin
                    clr_s        = 4'b0001 << code_r;
                    valid_next_s = 1'b0;
                    state_next_s = IDLE;
                end else begin
                    valid_next_s = valid_r;
                    state_next_s = HOLD;
                end
            end
            default: begin
                valid_next_s = 1'b0;
                state_next_s = IDLE;
            end
        endcase
    end

    // Pending update: a new rise beats a same-cycle clear; a rise on a bit
    // that stays pending is lost and flagged.
    always_comb begin
        pending_next_s  = (pending_r & ~clr_s) | rise_s;
        overflow_next_s = |(rise_s & pending_r & ~clr_s);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            code_r     <= 2'd0;
            valid_r    <= 1'b0;
            pending_r  <= 4'b0000;
            overflow_r <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            code_r     <= code_next_s;
            valid_r    <= valid_next_s;
            pending_r  <= pending_next_s;
            overflow_r <= overflow_next_s;
        end
    end

    assign code     = code_r;
    assign valid    = valid_r;
    assign pending  = pending_r;
    assign overflow = overflow_r;

endmodule

// File: doc/priority_encoder_42_seq.md
PRIORITY_ENCODER_42_SEQ -- requirements
Module: priority_encoder_42_seq

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on the rising edge.
REQ-002 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: req  input  4  asynchronous event request lines; bit i rising = event i.
REQ-004 SHALL have port: ready  input  1  consumer accepts the current code.
REQ-005 SHALL have port: code  output  2  binary index of the event being presented.
REQ-006 SHALL have port: valid  output  1  code is meaningful; held until accepted.
REQ-007 SHALL have port: pending  output  4  registered set of captured, unserved events.
REQ-008 SHALL have port: overflow  output  1  one-cycle pulse: event on an already-pending bit was lost.

Function
REQ-009 SHALL pass each req bit through a 2-flop synchronizer plus a third delay flop; rise_i = sync2_i & ~sync3_i.
REQ-010 SHALL set pending[i] on the edge where rise_i=1; pending[i] holds until served.
REQ-011 SHALL implement FSM IDLE/HOLD: IDLE with pending!=0 loads code, sets valid=1 and moves to HOLD; IDLE with pending==0 stays with valid=0.
REQ-012 In HOLD, code and valid SHALL stay stable until valid&ready; on handshake, clear pending[code], drive valid=0 and return to IDLE.
REQ-013 Throughput SHALL be at most one code per 2 cycles; ready in IDLE SHALL be ignored.
REQ-014 Latency: req sampled high at edge 0 -> pending set at edge 2 -> valid=1 after edge 3.
REQ-015 Default selection SHALL be fixed priority, bit 3 highest, bit 0 lowest, matching the 2-to-4 code map 11,10,01,00.
REQ-016 If rise_i and clearing of pending[i] happen in the same cycle, set SHALL win; no overflow.
REQ-017 If rise_i=1 with pending[i] already 1 and not being cleared, overflow SHALL pulse for 1 cycle and pending SHALL be unchanged.
REQ-018 Multiple simultaneous rises SHALL all be captured in the same cycle.
REQ-019 A req held high SHALL generate exactly one event; a new event needs a low phase of at least 1 sampled cycle.

Reset
REQ-020 On rst_n=0, the block SHALL immediately clear sync flops, pending=0, code=0, valid=0, overflow=0, FSM=IDLE and RR pointer=0.
REQ-021 Reset mid-HOLD SHALL discard the presented code without a handshake; events that were high during reset SHALL NOT generate events after release.
REQ-022 Reset release SHALL be the only reset-related requirement; deassertion synchronization is done outside the block.

Configuration
REQ-023 With ENC_RR_EN defined, selection SHALL be round-robin: search descending from (last_served-1) mod 4; last_served reset value is 0, so the first order is 3,2,1,0.
REQ-024 Without ENC_RR_EN, REQ-015 fixed priority SHALL apply and no pointer register SHALL exist.

Structure
REQ-025 Package enc_pkg SHALL hold N_REQ=4, CODE_W=2, and the FSM state enum (IDLE, HOLD).
REQ-026 The per-bit synchronizer plus edge detector SHALL be sub-module req_edge_sync, instantiated 4 times.

Verification
REQ-027 req=4'b0100 pulse for 3 cycles, ready=1 -> valid after edge 3, code=2'b10, pending returns to 0 after handshake.
REQ-028 req=4'b1001 rises together, ready=1 -> fixed mode: codes 11 then 00; pending goes 1001 -> 0001 -> 0000.
REQ-029 ready=0, code=3 held for 10 cycles -> code and valid stable; a second rise on bit 3 -> overflow pulses once, pending=1000.
REQ-030 Rise on bit 1 in the handshake cycle serving code 01 -> pending[1] stays 1, overflow=0, code 01 presented again.
REQ-031 ENC_RR_EN with req=1111 continuously re-pulsed -> codes 11,10,01,00,11 in order.
REQ-032 rst_n=0 during HOLD -> valid=0 and pending=0 at once; after release, no code until a new rise.
